// File: rtl/rename_regfile_mp.sv
// -----------------------------------------------------------------------------
// rename_regfile_mp
//
// Architectural register file with per-register rename tags for the Tomasulo
// core. Sits between decode/dispatch and the ROB.
//
//   clk, rst        clock; synchronous active-high reset
//   rdy             global enable; low holds every register
//   flush           mispredict; drops all pending renames
//   rd_addr         NRD read indices (port i at slice i)
//   rd_ready/val/tag combinational read results per port
//   disp_en/rd/tag  one rename per cycle
//   cmt_en/rd/tag/val NCMT in-order commits per cycle, port 0 oldest
//
// Optional build macro: RRF_COMMIT_BYPASS_EN forwards same-cycle commits
// straight to the read ports. When undefined, a committed value becomes
// visible on the cycle after the commit.
//
// Register 0 is hardwired to zero: it always reads ready with value and tag 0,
// and writes to it are discarded.
// -----------------------------------------------------------------------------
module rename_regfile_mp #(
  parameter  int NREG  = 32,
  parameter  int XLEN  = 32,
  parameter  int ROB_W = 4,
  parameter  int NRD   = 2,
  parameter  int NCMT  = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD-1:0]       rd_ready,
  output logic [NRD*XLEN-1:0]  rd_val,
  output logic [NRD*ROB_W-1:0] rd_tag,
  input  logic                 disp_en,
  input  logic [AW-1:0]        disp_rd,
  input  logic [ROB_W-1:0]     disp_tag,
  input  logic [NCMT-1:0]      cmt_en,
  input  logic [NCMT*AW-1:0]   cmt_rd,
  input  logic [NCMT*ROB_W-1:0] cmt_tag,
  input  logic [NCMT*XLEN-1:0] cmt_val
);

  logic [XLEN-1:0]  val_q  [NREG];
  logic [XLEN-1:0]  val_d  [NREG];
  logic [ROB_W-1:0] tag_q  [NREG];
  logic [ROB_W-1:0] tag_d  [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;

  // ---------------------------------------------------------------------------
  // Next-state: commits (oldest to youngest), then dispatch, then flush.
  // Later steps overwrite earlier ones, which gives the required priorities:
  // the youngest commit value wins, a same-cycle rename keeps the register
  // busy, and flush wipes every rename including the one dispatched now.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a full default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;

    if (rdy) begin
      for (int k = 0; k < NCMT; k++) begin
        if (cmt_en[k] && (cmt_rd[k*AW +: AW] != '0)) begin
          // Commits arrive in program order, so the value always lands.
          val_d[cmt_rd[k*AW +: AW]] = cmt_val[k*XLEN +: XLEN];
          // Only the commit of the producer named in the tag releases it;
          // match against the stored (pre-dispatch) tag.
          if (tag_q[cmt_rd[k*AW +: AW]] == cmt_tag[k*ROB_W +: ROB_W]) begin
            busy_d[cmt_rd[k*AW +: AW]] = 1'b0;
          end
        end
      end

      if (disp_en && (disp_rd != '0)) begin
        busy_d[disp_rd] = 1'b1;
        tag_d[disp_rd]  = disp_tag;
      end

      if (flush) begin
        busy_d = '0;
        for (int r = 0; r < NREG; r++) begin
          tag_d[r] = '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. rst outranks rdy; rdy gating lives in the next-state logic.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the value array is reset explicitly because reads after reset
      // must return zero; this keeps it in flops rather than a RAM macro.
      busy_q <= '0;
      for (int r = 0; r < NREG; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int r = 0; r < NREG; r++) begin
        val_q[r] <= val_d[r];
        tag_q[r] <= tag_d[r];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: zero-latency view of the current state. A busy register still
  // returns its last committed value alongside the pending tag.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ready = '1;
    rd_val   = '0;
    rd_tag   = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr[i*AW +: AW] != '0) begin
        rd_ready[i]                 = !busy_q[rd_addr[i*AW +: AW]];
        rd_val[i*XLEN +: XLEN]      = val_q[rd_addr[i*AW +: AW]];
        rd_tag[i*ROB_W +: ROB_W]    = busy_q[rd_addr[i*AW +: AW]]
                                      ? tag_q[rd_addr[i*AW +: AW]] : '0;
`ifdef RRF_COMMIT_BYPASS_EN
        // Forward the commit of the pending producer this same cycle.
        // Ascending scan lets the youngest matching port win.
        if (rdy && busy_q[rd_addr[i*AW +: AW]]) begin
          for (int k = 0; k < NCMT; k++) begin
            if (cmt_en[k]
                && (cmt_rd[k*AW +: AW] == rd_addr[i*AW +: AW])
                && (cmt_tag[k*ROB_W +: ROB_W] == tag_q[rd_addr[i*AW +: AW]])) begin
              rd_ready[i]              = 1'b1;
              rd_val[i*XLEN +: XLEN]   = cmt_val[k*XLEN +: XLEN];
              rd_tag[i*ROB_W +: ROB_W] = '0;
            end
          end
        end
`endif
      end
    end
  end

endmodule

// File: doc/rename_regfile_mp.md
Name: rename_regfile_mp

Overview:
- Parametrised architectural register file with rename tags for the Tomasulo core.
- Sits between decode/dispatch and the ROB.
- Provides NRD combinational read ports that return value, ready and ROB tag.
- Accepts one dispatch rename per cycle and NCMT in-order commits per cycle; supports a global flush on mispredict.

Parameters:
- NREG, 32, number of architectural registers (power of 2); reg 0 hardwired to zero.
- XLEN, 32, data width.
- ROB_W, 4, ROB tag width.
- NRD, 2, number of read ports.
- NCMT, 2, commit ports per cycle; port 0 is the oldest.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low = hold all state
- flush  in  1  mispredict; clears all rename state
- rd_addr  in  NRD*log2(NREG)  read register indices, port i at slice i
- rd_ready  out  NRD  1 = value valid (no pending rename)
- rd_val  out  NRD*XLEN  register value (committed value even if busy)
- rd_tag  out  NRD*ROB_W  pending ROB tag; 0 when ready
- disp_en  in  1  dispatch writes a rename
- disp_rd  in  log2(NREG)  destination register
- disp_tag  in  ROB_W  ROB entry of the producer
- cmt_en  in  NCMT  commit valid per port
- cmt_rd  in  NCMT*log2(NREG)  committed destination
- cmt_tag  in  NCMT*ROB_W  committing ROB entry
- cmt_val  in  NCMT*XLEN  committed value

Behaviour:
- State per register: val[XLEN], busy, tag[ROB_W].
- Reset: all val=0, busy=0, tag=0. Read outputs after reset: rd_ready=1, rd_val=0, rd_tag=0 for every port.
- Reads are combinational from current state, with zero latency:
  - rd_ready = !busy
  - rd_val = val
  - rd_tag = busy ? tag : 0
- Address 0 always reads ready=1, val=0, tag=0. Writes to reg 0 (dispatch or commit) are ignored.
- All updates occur on posedge clk, and only when rdy=1. When rdy=0, state holds and reads stay live. rst has priority over rdy.
- Commit, port k with cmt_en[k] and rd != 0:
  - val[rd] <= cmt_val[k], regardless of tag. The ROB commits in order, so the architectural value is always updated.
  - busy[rd] cleared only if tag[rd] == cmt_tag[k] and no dispatch targets rd this cycle.
- Several commit ports to the same rd in one cycle:
  - The highest-index (youngest) port's value wins.
  - busy clears if any matching port's tag equals the stored tag.
- Dispatch (disp_en, rd != 0): busy[rd] <= 1, tag[rd] <= disp_tag. This overrides any same-cycle commit busy-clear on that rd. The commit value is still written.
- Flush:
  - All busy <= 0 and all tag <= 0.
  - Same-cycle commits still write their values, since commit precedes flush.
  - Same-cycle dispatch is dropped.
- rst mid-operation discards all pending renames and values on that edge.
- No internal FSM beyond per-register state. Update order is fixed: commits (port 0 → NCMT-1), then dispatch, then flush.

Optional Feature:
- Macro RRF_COMMIT_BYPASS_EN.
- Defined: each read port forwards same-cycle commits.
  - If a read address is busy and some cmt_en[k] has cmt_rd == addr and cmt_tag == stored tag, the port returns rd_ready=1, rd_val=cmt_val[k], rd_tag=0.
  - If several ports match, the youngest wins.
  - Forwarding is active only when rdy=1.
- Undefined: reads reflect registered state only, so a committed value becomes visible one cycle later.

Test Plan:
- Reset then read regs 0, 5, 31 → ready=1, val=0, tag=0 on all ports.
- Dispatch rd=5 tag=3; next cycle read 5 → ready=0, tag=3. Commit rd=5 tag=3 val=0xDEADBEEF; next cycle read 5 → ready=1, val=0xDEADBEEF.
- Rename rd=7 tag=2, then rename rd=7 tag=6. Commit tag=2 val=0x11 → val=0x11, ready=0, tag=6. Commit tag=6 val=0x22 → ready=1, val=0x22.
- Same cycle: dispatch rd=9 tag=4 and commit rd=9 with matching old tag 1, val=0x55 → val=0x55, busy=1, tag=4. Same cycle: commit ports 0 and 1 both to rd=3 with vals 0xA and 0xB → val=0xB.
- Busy regs 2, 4, 8; assert flush together with commit rd=4 val=0x77 and dispatch rd=10 tag=5 → all ready=1, reg4=0x77, reg10 not busy. Hold rdy=0 with a dispatch → no state change.
- With RRF_COMMIT_BYPASS_EN: reg 12 busy tag=1; commit rd=12 tag=1 val=0x99 while reading 12 → same-cycle rd_ready=1, rd_val=0x99. Without the macro → ready=0 that cycle, ready=1 and 0x99 the next.
